// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the alu_arbiter, and the writeback consumer.
// rsp_flags exists only when ALU_FLAGS_EN is defined.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [1:0]        req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [1:0]        req1_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
`ifdef ALU_FLAGS_EN
    logic [3:0]        rsp_flags;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_result
`ifdef ALU_FLAGS_EN
        , input rsp_flags
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_result
`ifdef ALU_FLAGS_EN
        , output rsp_flags
`endif
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ADD/SUB/AND/ORR ALU between two requesters with a registered
// single-entry result slot. Define ALU_FLAGS_EN to register and expose {N,Z,C,V} on rsp_flags.
module alu_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;

    state_t            state;
    logic              ptr;
    logic              id_p1;
    logic [DATA_W-1:0] result_p1;
    logic              slot_free;
    logic              gnt0;
    logic              gnt1;
    logic              gnt;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [1:0]        op_p0;
    logic [DATA_W-1:0] res_p0;
`ifdef ALU_FLAGS_EN
    logic [3:0]        flags_p0;
    logic [3:0]        flags_p1;
`endif

    function automatic logic [DATA_W-1:0] alu_op(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    // Overflow is detected on a sign-extended DATA_W+1 result: the top two bits disagree.
    function automatic logic [3:0] alu_flags(input logic [1:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] r);
        logic [DATA_W:0]        ext;
        logic signed [DATA_W:0] sa;
        logic signed [DATA_W:0] sb;
        logic signed [DATA_W:0] sr;
        logic                   c;
        logic                   v;
        sa  = $signed({a[DATA_W-1], a});
        sb  = $signed({b[DATA_W-1], b});
        ext = '0;
        sr  = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                sr  = sa + sb;
                c   = ext[DATA_W];
                v   = sr[DATA_W] ^ sr[DATA_W-1];
            end
            OP_SUB: begin
                sr = sa - sb;
                c  = (a >= b);
                v  = sr[DATA_W] ^ sr[DATA_W-1];
            end
            default: ;
        endcase
        return {r[DATA_W-1], (r == '0), c, v};
    endfunction
`endif

    // Stage p0: grant and ALU evaluation on the selected requester
    always_comb begin
        slot_free = (state == EMPTY) || bus.rsp_ready;
        gnt0      = slot_free && bus.req0_valid && (!bus.req1_valid || !ptr);
        gnt1      = slot_free && bus.req1_valid && (!bus.req0_valid || ptr);
        gnt       = gnt0 || gnt1;
        a_p0      = gnt1 ? bus.req1_a  : bus.req0_a;
        b_p0      = gnt1 ? bus.req1_b  : bus.req0_b;
        op_p0     = gnt1 ? bus.req1_op : bus.req0_op;
        res_p0    = alu_op(op_p0, a_p0, b_p0);
    end

`ifdef ALU_FLAGS_EN
    assign flags_p0 = alu_flags(op_p0, a_p0, b_p0, res_p0);
`endif

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Stage p1: result slot; a grant reloads it even while it is being drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ptr       <= PRIO_INIT;
            id_p1     <= 1'b0;
            result_p1 <= '0;
`ifdef ALU_FLAGS_EN
            flags_p1  <= 4'd0;
`endif
        end else begin
            case (state)
                EMPTY: if (gnt) state <= FULL;
                FULL:  if (bus.rsp_ready && !gnt) state <= EMPTY;
            endcase
            if (gnt) begin
                id_p1     <= gnt1;
                result_p1 <= res_p0;
                ptr       <= gnt0;
`ifdef ALU_FLAGS_EN
                flags_p1  <= flags_p0;
`endif
            end
        end
    end

    assign bus.rsp_valid  = (state == FULL);
    assign bus.rsp_id     = id_p1;
    assign bus.rsp_result = result_p1;
`ifdef ALU_FLAGS_EN
    assign bus.rsp_flags  = flags_p1;
`endif
endmodule
